// File: rtl/timer_irq_ctrl_pkg.sv
// timer_irq_ctrl_pkg
//   Shared constants for the interval timer peripheral: base address,
//   register offsets, TCON bit positions and the offset decoder.
//   The base address is also reused by the bus decoder and the
//   digit/LED/UART blocks.
package timer_irq_ctrl_pkg;

    localparam logic [31:0] TIMER_BASE_ADDR = 32'h4000_0000;

    localparam logic [3:0] TH_OFF   = 4'h0;
    localparam logic [3:0] TL_OFF   = 4'h4;
    localparam logic [3:0] TCON_OFF = 4'h8;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_ST = 2;

    typedef enum logic [1:0] {
        SEL_TH   = 2'd0,
        SEL_TL   = 2'd1,
        SEL_TCON = 2'd2,
        SEL_NONE = 2'd3
    } reg_sel_e;

    // Byte lanes (off[1:0]) are ignored; only the word offset selects.
    function automatic reg_sel_e decode_off(input logic [3:0] off);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (off[3:2] == TH_OFF[3:2])        sel = SEL_TH;
        else if (off[3:2] == TL_OFF[3:2])   sel = SEL_TL;
        else if (off[3:2] == TCON_OFF[3:2]) sel = SEL_TCON;
        return sel;
    endfunction

endpackage

// File: rtl/timer_irq_ctrl_tick.sv
// tick_divider
//   Prescaler for the interval timer. Counts 0..PRESCALE-1 while en=1 and
//   pulses tick in the cycle the count reaches PRESCALE-1. Held at 0
//   whenever en=0 so a re-enable always starts a full period.
//   Ports: clk, reset (sync, active-high), en (count enable), tick (pulse).
module tick_divider #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] r_cnt;
    logic        w_last;

    assign w_last = (r_cnt == LAST);
    assign tick   = en & w_last;

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl
//   Memory-mapped interval timer and interrupt controller.
//   TH (+0) reload value, TL (+4) up-counter, TCON (+8) {ST,IE,EN}.
//   TL counts on each prescaler tick; from all-ones it reloads from TH
//   and raises an overflow event, which latches ST when IE=1.
//   Ports:
//     clk, reset        clock, synchronous active-high reset
//     addr, wdata       CPU data bus address / store data
//     mem_write         store strobe
//     mem_read, rdata   load strobe, combinational load data
//     kernel_mode       CPU inside handler, masks irq
//     irq               interrupt request (ST & IE & ~kernel_mode)
//     tick              prescaler tick pulse
module timer_irq_ctrl
    import timer_irq_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = TIMER_BASE_ADDR,
    parameter int          PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_write,
    input  logic        mem_read,
    output logic [31:0] rdata,
    input  logic        kernel_mode,
    output logic        irq,
    output logic        tick
);

    logic [31:0] r_th;
    logic [31:0] r_tl;
    logic        r_en;
    logic        r_ie;
    logic        r_st;

    reg_sel_e    w_sel;
    logic        w_hit;
    logic        w_wr_th;
    logic        w_wr_tl;
    logic        w_wr_tcon;
    logic        w_tick;
    logic        w_tl_max;
    logic        w_ovf;
    logic [31:0] w_tcon;

    assign w_sel     = decode_off(addr[3:0]);
    assign w_hit     = (addr[31:4] == BASE_ADDR[31:4]) && (w_sel != SEL_NONE);
    assign w_wr_th   = mem_write && w_hit && (w_sel == SEL_TH);
    assign w_wr_tl   = mem_write && w_hit && (w_sel == SEL_TL);
    assign w_wr_tcon = mem_write && w_hit && (w_sel == SEL_TCON);

    tick_divider #(
        .PRESCALE (PRESCALE)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .en    (r_en),
        .tick  (w_tick)
    );

    assign w_tl_max = (r_tl == 32'hFFFF_FFFF);
    // A TL store overrides the tick, so no reload and no overflow event.
    assign w_ovf    = w_tick && !w_wr_tl && w_tl_max;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_th <= '0;
            r_tl <= '0;
            r_en <= 1'b0;
            r_ie <= 1'b0;
            r_st <= 1'b0;
        end else begin
            if (w_wr_th) r_th <= wdata;

            // Reload uses the pre-edge TH even if TH is written this cycle.
            if (w_wr_tl)     r_tl <= wdata;
            else if (w_tick) r_tl <= w_tl_max ? r_th : r_tl + 32'd1;

            if (w_wr_tcon) begin
                r_en <= wdata[TCON_EN];
                r_ie <= wdata[TCON_IE];
                // A concurrent overflow survives an ISR clear if IE stays set.
                r_st <= wdata[TCON_ST] | (w_ovf & wdata[TCON_IE]);
            end else if (w_ovf && r_ie) begin
                r_st <= 1'b1;
            end
        end
    end

    assign w_tcon = {29'd0, r_st, r_ie, r_en};

    always_comb begin
        rdata = '0;
        if (mem_read && w_hit) begin
            case (w_sel)
                SEL_TH:   rdata = r_th;
                SEL_TL:   rdata = r_tl;
                SEL_TCON: rdata = w_tcon;
                default:  rdata = '0;
            endcase
        end
    end

    assign irq  = r_st & r_ie & ~kernel_mode;
    assign tick = w_tick;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
module tb_timer_irq_ctrl;

    localparam logic [31:0] A = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        wr1 = 1'b0;
    logic        wr4 = 1'b0;
    logic        mem_read = 1'b0;
    logic        kernel_mode = 1'b0;
    logic [31:0] rdata1, rdata4;
    logic        irq1, irq4, tick1, tick4;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    timer_irq_ctrl #(.BASE_ADDR(A), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
        .mem_write(wr1), .mem_read(mem_read), .rdata(rdata1),
        .kernel_mode(kernel_mode), .irq(irq1), .tick(tick1)
    );

    timer_irq_ctrl #(.BASE_ADDR(A), .PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
        .mem_write(wr4), .mem_read(mem_read), .rdata(rdata4),
        .kernel_mode(kernel_mode), .irq(irq4), .tick(tick4)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] act);
        if (exp_q.size() == 0) chk({tag, "_sb_underflow"}, act, 32'hDEAD_BEEF);
        else chk(tag, act, exp_q.pop_front());
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit u4, input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d;
        if (u4) wr4 = 1'b1; else wr1 = 1'b1;
        @(posedge clk);
        #1;
        wr1 = 1'b0; wr4 = 1'b0;
    endtask

    task automatic rd(input bit u4, input logic [31:0] a, input logic [31:0] e, input string tag);
        exp_q.push_back(e);
        addr = a; mem_read = 1'b1;
        #1;
        pop_chk(tag, u4 ? rdata4 : rdata1);
        mem_read = 1'b0;
    endtask

    task automatic sig(input string tag, input logic act, input logic e);
        exp_q.push_back({31'd0, e});
        pop_chk(tag, {31'd0, act});
    endtask

    initial begin
        step(3);
        reset = 1'b0;

        // reset state
        rd(0, A + 0, 32'h0, "rst_th");
        rd(0, A + 4, 32'h0, "rst_tl");
        rd(0, A + 8, 32'h0, "rst_tcon");
        sig("rst_irq", irq1, 1'b0);
        sig("rst_tick", tick1, 1'b0);

        // boot sequence, PRESCALE=1
        wr(0, A + 8, 32'h0);
        wr(0, A + 0, 32'hFFFF_8AD0);
        wr(0, A + 4, 32'hFFFF_FFFF);
        wr(0, A + 8, 32'h3);
        sig("boot_tick", tick1, 1'b1);
        rd(0, A + 4, 32'hFFFF_FFFF, "boot_tl_pre");
        sig("boot_irq_pre", irq1, 1'b0);
        step(1);
        rd(0, A + 4, 32'hFFFF_8AD0, "boot_reload");
        rd(0, A + 8, 32'h7, "boot_tcon");
        sig("boot_irq", irq1, 1'b1);
        wr(0, A + 8, 32'h3);
        sig("st_clr_irq", irq1, 1'b0);
        step(29998);
        rd(0, A + 4, 32'hFFFF_FFFF, "period_tl_max");
        rd(0, A + 8, 32'h3, "period_tcon_pre");
        sig("period_irq_pre", irq1, 1'b0);
        step(1);
        rd(0, A + 4, 32'hFFFF_8AD0, "period_reload");
        rd(0, A + 8, 32'h7, "period_tcon");
        sig("period_irq", irq1, 1'b1);

        // kernel masking and ISR protocol
        kernel_mode = 1'b1; #1;
        sig("kmode_mask", irq1, 1'b0);
        kernel_mode = 1'b0; #1;
        sig("kmode_unmask", irq1, 1'b1);
        wr(0, A + 8, 32'h7 & ~32'h6);
        rd(0, A + 8, 32'h1, "isr_clr_tcon");
        sig("isr_clr_irq", irq1, 1'b0);
        wr(0, A + 8, 32'h3);
        rd(0, A + 8, 32'h3, "isr_exit_tcon");
        sig("isr_exit_irq", irq1, 1'b0);

        // TCON write coinciding with overflow
        wr(0, A + 4, 32'hFFFF_FFFF);
        rd(0, A + 4, 32'hFFFF_FFFF, "tl_wr_wins");
        wr(0, A + 8, 32'h1);
        rd(0, A + 8, 32'h1, "ovf_wr1_tcon");
        rd(0, A + 4, 32'hFFFF_8AD0, "ovf_wr1_tl");
        wr(0, A + 8, 32'h3);
        wr(0, A + 4, 32'hFFFF_FFFF);
        wr(0, A + 8, 32'h3);
        rd(0, A + 8, 32'h7, "ovf_wr3_tcon");
        sig("ovf_wr3_irq", irq1, 1'b1);

        // TH write in the reload cycle: old TH loads
        wr(0, A + 4, 32'hFFFF_FFFF);
        wr(0, A + 0, 32'h0000_0100);
        rd(0, A + 4, 32'hFFFF_8AD0, "th_reload_tl");
        rd(0, A + 0, 32'h0000_0100, "th_reload_th");
        // EN=0 write: tick of that cycle still counts
        wr(0, A + 8, 32'h0);
        rd(0, A + 4, 32'hFFFF_8AD1, "en_off_tl");
        rd(0, A + 8, 32'h0, "en_off_tcon");

        // decode misses
        wr(0, A + 32'hC, 32'h1234_5678);
        wr(0, A + 32'h10, 32'h1234_5678);
        rd(0, A + 0, 32'h0000_0100, "dec_th");
        rd(0, A + 4, 32'hFFFF_8AD1, "dec_tl");
        rd(0, A + 8, 32'h0, "dec_tcon");
        rd(0, A + 32'hC, 32'h0, "dec_rd_c");
        rd(0, A + 32'h10, 32'h0, "dec_rd_10");
        wr(0, A + 32'hB, 32'h3);
        rd(0, A + 32'h8, 32'h3, "dec_byte_lane");

        // reset with irq high
        wr(0, A + 4, 32'hFFFF_FFFF);
        step(1);
        sig("pre_rst_irq", irq1, 1'b1);
        reset = 1'b1;
        step(1);
        sig("mid_rst_irq", irq1, 1'b0);
        rd(0, A + 0, 32'h0, "mid_rst_th");
        rd(0, A + 4, 32'h0, "mid_rst_tl");
        rd(0, A + 8, 32'h0, "mid_rst_tcon");
        reset = 1'b0;

        // PRESCALE=4 instance
        wr(1, A + 4, 32'hFFFF_FFFE);
        wr(1, A + 0, 32'h0000_0055);
        wr(1, A + 8, 32'h1);
        sig("p4_tick_c0", tick4, 1'b0);
        step(2);
        sig("p4_tick_c2", tick4, 1'b0);
        rd(1, A + 4, 32'hFFFF_FFFE, "p4_tl_c2");
        step(1);
        sig("p4_tick_c3", tick4, 1'b1);
        step(1);
        rd(1, A + 4, 32'hFFFF_FFFF, "p4_tl_c4");
        sig("p4_tick_c4", tick4, 1'b0);
        step(3);
        sig("p4_tick_c7", tick4, 1'b1);
        step(1);
        rd(1, A + 4, 32'h0000_0055, "p4_reload");
        rd(1, A + 8, 32'h1, "p4_tcon_ie0");
        step(2);
        wr(1, A + 8, 32'h0);
        step(3);
        rd(1, A + 4, 32'h0000_0055, "p4_frozen");
        sig("p4_frozen_tick", tick4, 1'b0);
        wr(1, A + 8, 32'h1);
        step(2);
        sig("p4_reen_c2", tick4, 1'b0);
        rd(1, A + 4, 32'h0000_0055, "p4_reen_tl");
        step(1);
        sig("p4_reen_c3", tick4, 1'b1);
        step(1);
        rd(1, A + 4, 32'h0000_0056, "p4_reen_inc");

        chk("sb_drain", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
